// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcode constants and FSM encoding for alu_seq
package alu_seq_pkg;

  localparam logic [2:0] OP_PLUS  = 3'd0;
  localparam logic [2:0] OP_MINUS = 3'd1;
  localparam logic [2:0] OP_AND   = 3'd2;
  localparam logic [2:0] OP_OR    = 3'd3;
  localparam logic [2:0] OP_INV   = 3'd4;
  localparam logic [2:0] OP_LAST  = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_LAST;
  endfunction

endpackage

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - request/response sequencer around an external combinational ALU
// Optional carry/zero flags enabled by defining ALU_SEQ_FLAGS_EN.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_opcode,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic              req_use_acc,
  input  logic              acc_clr,
  output logic [2:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_err,
  output logic              resp_carry,
  output logic              resp_zero,
  output logic [DATA_W-1:0] acc,
  output logic [CNT_W-1:0]  op_count
);

  state_t state_q, state_d;
  logic   accept;
  logic   exec;
  logic   done;
  logic   legal;

  assign accept = req_valid && req_ready;
  assign exec   = (state_q == EXEC);
  assign done   = resp_valid && resp_ready;
  assign legal  = op_legal(alu_opcode);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand registers feed the ALU directly so its inputs only change on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_opcode <= 3'd0;
      alu_a      <= '0;
      alu_b      <= '0;
    end else if (accept) begin
      alu_opcode <= req_opcode;
      alu_a      <= req_use_acc ? acc : req_a;
      alu_b      <= req_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_result <= '0;
      resp_err    <= 1'b0;
    end else if (exec) begin
      resp_result <= legal ? alu_out : '0;
      resp_err    <= !legal;
    end
  end

  // Clear has priority over the EXEC load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              acc <= '0;
    else if (acc_clr)        acc <= '0;
    else if (exec && legal)  acc <= alu_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    op_count <= '0;
    else if (done) op_count <= op_count + CNT_W'(1);
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic [DATA_W:0] sum_w;
  logic            carry_d;
  logic            carry_q;
  logic            zero_q;

  assign sum_w = {1'b0, alu_a} + {1'b0, alu_b};

  always_comb begin
    carry_d = 1'b0;
    case (alu_opcode)
      OP_PLUS:  carry_d = sum_w[DATA_W];
      OP_MINUS: carry_d = (alu_a < alu_b);
      default:  carry_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (exec) begin
      carry_q <= legal && carry_d;
      zero_q  <= legal && (alu_out == '0);
    end
  end

  assign resp_carry = carry_q;
  assign resp_zero  = zero_q;
`else
  assign resp_carry = 1'b0;
  assign resp_zero  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq with a behavioural 8-bit ALU
module tb_alu_seq;

`ifdef ALU_SEQ_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_opcode;
  logic [7:0]  req_a;
  logic [7:0]  req_b;
  logic        req_use_acc;
  logic        acc_clr;
  logic [2:0]  alu_opcode;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_out;
  logic        resp_valid;
  logic        resp_ready;
  logic [7:0]  resp_result;
  logic        resp_err;
  logic        resp_carry;
  logic        resp_zero;
  logic [7:0]  acc;
  logic [15:0] op_count;

  int n_checks = 0;
  int n_pass   = 0;

  alu_seq #(.DATA_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b), .req_use_acc(req_use_acc), .acc_clr(acc_clr),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .resp_err(resp_err), .resp_carry(resp_carry), .resp_zero(resp_zero),
    .acc(acc), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (alu_opcode)
      3'd0:    alu_out = alu_a + alu_b;
      3'd1:    alu_out = alu_a - alu_b;
      3'd2:    alu_out = alu_a & alu_b;
      3'd3:    alu_out = alu_a | alu_b;
      3'd4:    alu_out = ~alu_a;
      default: alu_out = 8'hAA;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Issue one request from IDLE and step to RESP, checking the 2-cycle latency.
  task automatic send(input string tag, input logic [2:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic use_acc, input logic [7:0] exp_a,
                      input logic clr_in_exec);
    check({tag, "_req_ready"}, req_ready, 1);
    req_valid = 1'b1; req_opcode = op; req_a = a; req_b = b; req_use_acc = use_acc;
    @(posedge clk); #1;
    req_valid = 1'b0; req_use_acc = 1'b0;
    req_a = 8'h5A; req_b = 8'hA5; req_opcode = 3'd3;
    check({tag, "_exec_valid"}, resp_valid, 0);
    check({tag, "_exec_alu_a"}, alu_a, exp_a);
    acc_clr = clr_in_exec;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    check({tag, "_resp_valid"}, resp_valid, 1);
  endtask

  task automatic pop(input string tag);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check({tag, "_pop_req_ready"}, req_ready, 1);
    check({tag, "_pop_valid"}, resp_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_opcode = 3'd0; req_a = 8'h00; req_b = 8'h00;
    req_use_acc = 1'b0; acc_clr = 1'b0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_acc", acc, 0);
    check("rst_cnt", op_count, 0);
    check("rst_valid", resp_valid, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_op", alu_opcode, 0);
    check("rst_result", resp_result, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_req_ready", req_ready, 1);

    send("plus", 3'd0, 8'hF0, 8'h20, 1'b0, 8'hF0, 1'b0);
    check("plus_result", resp_result, 8'h10);
    check("plus_carry", resp_carry, FL ? 1 : 0);
    check("plus_zero", resp_zero, 0);
    check("plus_err", resp_err, 0);
    check("plus_acc", acc, 8'h10);
    check("plus_alu_op", alu_opcode, 0);
    pop("plus");
    check("plus_cnt", op_count, 1);

    send("minus", 3'd1, 8'h05, 8'h05, 1'b0, 8'h05, 1'b0);
    check("minus_result", resp_result, 8'h00);
    check("minus_zero", resp_zero, FL ? 1 : 0);
    check("minus_carry", resp_carry, 0);
    check("minus_acc", acc, 8'h00);
    pop("minus");

    send("accminus", 3'd1, 8'h77, 8'h01, 1'b1, 8'h00, 1'b0);
    check("accminus_result", resp_result, 8'hFF);
    check("accminus_carry", resp_carry, FL ? 1 : 0);
    check("accminus_zero", resp_zero, 0);
    check("accminus_acc", acc, 8'hFF);
    pop("accminus");
    check("accminus_cnt", op_count, 3);

    send("illegal", 3'd6, 8'h03, 8'h04, 1'b0, 8'h03, 1'b0);
    check("illegal_err", resp_err, 1);
    check("illegal_result", resp_result, 0);
    check("illegal_carry", resp_carry, 0);
    check("illegal_zero", resp_zero, 0);
    check("illegal_acc", acc, 8'hFF);
    pop("illegal");
    check("illegal_cnt", op_count, 4);

    send("hold", 3'd2, 8'hCC, 8'hAA, 1'b0, 8'hCC, 1'b0);
    req_valid = 1'b1; req_opcode = 3'd3; req_a = 8'h01; req_b = 8'h02;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_valid", resp_valid, 1);
      check("hold_result", resp_result, 8'h88);
      check("hold_err", resp_err, 0);
      check("hold_req_ready", req_ready, 0);
      check("hold_alu_a", alu_a, 8'hCC);
    end
    req_valid = 1'b0;
    check("hold_cnt_before", op_count, 4);
    pop("hold");
    check("hold_cnt", op_count, 5);
    check("hold_ignored_alu_a", alu_a, 8'hCC);
    check("hold_ignored_alu_b", alu_b, 8'hAA);
    check("hold_acc", acc, 8'h88);

    send("clr", 3'd4, 8'h0F, 8'h00, 1'b0, 8'h0F, 1'b1);
    check("clr_result", resp_result, 8'hF0);
    check("clr_acc", acc, 8'h00);
    pop("clr");
    check("clr_cnt", op_count, 6);

    send("rstresp", 3'd3, 8'h11, 8'h22, 1'b0, 8'h11, 1'b0);
    check("rstresp_result", resp_result, 8'h33);
    rst_n = 1'b0;
    #1;
    check("rstresp_valid", resp_valid, 0);
    check("rstresp_cnt", op_count, 0);
    check("rstresp_acc", acc, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rstresp_req_ready", req_ready, 1);

    req_valid = 1'b1; req_opcode = 3'd0; req_a = 8'h40; req_b = 8'h01;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rstexec_valid", resp_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rstexec_no_resp", resp_valid, 0);
    end
    check("rstexec_cnt", op_count, 0);
    check("rstexec_acc", acc, 0);

    send("final", 3'd0, 8'h01, 8'h01, 1'b0, 8'h01, 1'b0);
    check("final_result", resp_result, 8'h02);
    check("final_carry", resp_carry, 0);
    pop("final");
    check("final_cnt", op_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
